neuron_seq_ctrl: RTL and testbench

NEURON_SEQ_CTRL -- requirements
Module: neuron_seq_ctrl

---
 rtl/nn_pkg.sv | 27 ++
 rtl/neuron_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_neuron_seq_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg -- definitions shared by the neuron sequencing logic.
//   N_MAX_DEF : default largest input count per neuron evaluation
//   CNT_W_DEF : default input counter width (2**CNT_W_DEF > N_MAX_DEF)
//   ACC_W_DEF : default MAC accumulator / result width
//   ST_*      : FSM state encodings; state_t wraps them as an enum so that
//               schedulers built on top of this package use the same values.
package nn_pkg;

  localparam int N_MAX_DEF = 64;
  localparam int CNT_W_DEF = 7;
  localparam int ACC_W_DEF = 18;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    FETCH = ST_FETCH,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl -- sequences one neuron evaluation: clear the MAC, stream
// N operand/weight pairs through the loader and weight ROM, let the MAC
// drain, then capture (and optionally ReLU) the accumulator.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   start, abort    : begin an evaluation (IDLE only) / cancel a running one
//   num_inputs      : pair count N, sampled with start (valid 1..N_MAX)
//   relu_en         : clamp negative results to zero, sampled with start
//   mac_in          : current accumulator value from the MAC
//   push_en, mem_en : advance loader / read weight ROM (FETCH cycles)
//   mac_en          : MAC accumulate enable, push_en delayed one cycle
//   mac_clr         : one-cycle accumulator clear (CLEAR cycle)
//   busy, done      : not-IDLE flag / one-cycle completion pulse
//   result          : captured neuron output, held until the next capture
// Every output is a register updated together with the next state.
module neuron_seq_ctrl
  import nn_pkg::*;
#(
  parameter int N_MAX = N_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_inputs,
  input  logic             relu_en,
  input  logic [ACC_W-1:0] mac_in,
  output logic             push_en,
  output logic             mem_en,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  state_t           state;
  logic [CNT_W-1:0] cnt;       // FETCH: pairs left; DRAIN: 0 = first, 1 = second cycle
  logic             relu_lat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      relu_lat <= 1'b0;
      push_en  <= 1'b0;
      mem_en   <= 1'b0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      // The loader and ROM present data one cycle after the push, so the
      // accumulate enable trails push_en by exactly one register.
      mac_en  <= push_en;
      mac_clr <= 1'b0;
      done    <= 1'b0;

      if (abort && (state == CLEAR || state == FETCH || state == DRAIN)) begin
        // Cancel: all enables drop in the same cycle IDLE is entered,
        // including the pending mac_en stage; result is left untouched.
        state   <= IDLE;
        cnt     <= '0;
        push_en <= 1'b0;
        mem_en  <= 1'b0;
        mac_en  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              busy     <= 1'b1;
              relu_lat <= relu_en;
              if (num_inputs != '0 && num_inputs <= CNT_W'(N_MAX)) begin
                state   <= CLEAR;
                cnt     <= num_inputs;
                mac_clr <= 1'b1;
              end else begin
                // Out-of-range count: report completion immediately with 0.
                state  <= DONE;
                done   <= 1'b1;
                result <= '0;
              end
            end
          end
          CLEAR: begin
            state   <= FETCH;
            push_en <= 1'b1;
            mem_en  <= 1'b1;
          end
          FETCH: begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state   <= DRAIN;
              push_en <= 1'b0;
              mem_en  <= 1'b0;
            end
          end
          DRAIN: begin
            if (cnt == '0) begin
              cnt <= CNT_W'(1);
            end else begin
              cnt    <= '0;
              state  <= DONE;
              done   <= 1'b1;
              result <= (relu_lat && mac_in[ACC_W-1]) ? '0 : mac_in;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            push_en <= 1'b0;
            mem_en  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb_neuron_seq_ctrl -- directed bench for neuron_seq_ctrl. A loader/ROM/MAC
// environment model produces mac_in from the DUT's enables. Each evaluation
// is planned as a cycle timeline (busy, clear, fetch window, accumulate
// window, done, captured value) derived from N and the start cycle; a
// negedge process compares every output against that timeline each cycle.
module tb_neuron_seq_ctrl;

  localparam int CNT_W = 7;
  localparam int ACC_W = 18;
  localparam int MAXC  = 2000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_inputs = '0;
  logic             relu_en = 1'b0;
  logic [ACC_W-1:0] mac_in;
  logic             push_en, mem_en, mac_en, mac_clr, busy, done;
  logic [ACC_W-1:0] result;

  always #5 clk = ~clk;

  neuron_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_inputs(num_inputs), .relu_en(relu_en), .mac_in(mac_in),
    .push_en(push_en), .mem_en(mem_en), .mac_en(mac_en), .mac_clr(mac_clr),
    .busy(busy), .done(done), .result(result)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment: loader + ROM + MAC ----------------
  int               x [64];
  int               w [64];
  int               idx;
  int               op_a, op_b;
  logic [ACC_W-1:0] acc;
  bit               ovr_on = 1'b0;
  logic [ACC_W-1:0] ovr_val = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0; idx <= 0; op_a <= 0; op_b <= 0;
    end else begin
      if (push_en && idx < 64) begin
        op_a <= x[idx]; op_b <= w[idx]; idx <= idx + 1;
      end
      if (mac_clr) begin
        acc <= '0; idx <= 0;
      end else if (mac_en) begin
        acc <= acc + ACC_W'(op_a * op_b);
      end
    end
  end
  assign mac_in = ovr_on ? ovr_val : acc;

  // ---------------- expected timeline ----------------
  bit               e_busy [MAXC];
  bit               e_clr  [MAXC];
  bit               e_push [MAXC];
  bit               e_mac  [MAXC];
  bit               e_done [MAXC];
  logic [ACC_W-1:0] e_res  [MAXC];

  int errors = 0;
  int checks = 0;
  int last_done = -1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      chk("busy",    busy,    e_busy[cyc]);
      chk("mac_clr", mac_clr, e_clr[cyc]);
      chk("push_en", push_en, e_push[cyc]);
      chk("mem_en",  mem_en,  e_push[cyc]);
      chk("mac_en",  mac_en,  e_mac[cyc]);
      chk("done",    done,    e_done[cyc]);
      chk("result",  result,  e_res[cyc]);
      if (done === 1'b1) last_done = cyc;
    end
  end

  task automatic fill_res(int from, logic [ACC_W-1:0] v);
    for (int c = from; c < MAXC; c++) e_res[c] = v;
  endtask

  // Neuron output from the rules: dot product of the first n pairs (or the
  // forced accumulator value), wrapped to ACC_W bits, ReLU on the sign.
  function automatic logic [ACC_W-1:0] expect_val(int n, bit relu);
    int s = 0;
    logic [ACC_W-1:0] v;
    for (int k = 0; k < n; k++) s += x[k] * w[k];
    v = ovr_on ? ovr_val : ACC_W'(s);
    if (relu && v[ACC_W-1]) v = '0;
    return v;
  endfunction

  // start high in cycle t; abort_a = offset of an abort cycle (<=0: none).
  task automatic plan(int t, int n, bit relu, int abort_a);
    int last;
    if (n == 0 || n > 64) begin
      e_busy[t+1] = 1'b1; e_done[t+1] = 1'b1;
      fill_res(t + 1, '0);
      return;
    end
    if (abort_a > n + 3) abort_a = 0;  // abort in DONE/IDLE is ignored
    last = (abort_a > 0) ? t + abort_a : t + n + 4;
    for (int c = t + 1; c <= last; c++) begin
      e_busy[c] = 1'b1;
      e_clr[c]  = (c == t + 1);
      e_push[c] = (c >= t + 2 && c <= t + n + 1);
      e_mac[c]  = (c >= t + 3 && c <= t + n + 2);
      e_done[c] = (c == t + n + 4);
    end
    if (abort_a <= 0) fill_res(t + n + 4, expect_val(n, relu));
  endtask

  int t0;

  task automatic run(int n, bit relu, int abort_a, int restart_a);
    @(posedge clk); #2;
    t0 = cyc;
    start = 1'b1; num_inputs = CNT_W'(n); relu_en = relu;
    plan(t0, n, relu, abort_a);
    for (int k = 1; k <= n + 6; k++) begin
      @(posedge clk); #2;
      start = (k == restart_a);
      abort = (k == abort_a);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin x[k] = 0; w[k] = 0; end
    for (int c = 0; c < MAXC; c++) e_res[c] = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_push", push_en, 0);
    chk("rst_result", result, 0);
    #21 reset = 1'b1;
    repeat (2) @(posedge clk);

    // N=3 dot product: 3*2 + 5*4 + 7*6 = 68, done 7 cycles after start.
    x[0] = 3; x[1] = 5; x[2] = 7; w[0] = 2; w[1] = 4; w[2] = 6;
    run(3, 1'b0, 0, 0);
    chk("pin_dot3", result, 68);
    chk("pin_lat3", last_done - t0, 7);

    // Forced negative accumulator at capture.
    ovr_on = 1'b1; ovr_val = 18'h3FFF6;
    run(2, 1'b1, 0, 0);
    chk("pin_relu_neg", result, 0);
    run(2, 1'b0, 0, 0);
    chk("pin_norelu_neg", result, 18'h3FFF6);
    ovr_on = 1'b0;

    // Out-of-range counts: immediate done, result 0.
    run(0, 1'b0, 0, 0);
    chk("pin_lat0", last_done - t0, 1);
    chk("pin_res0", result, 0);
    run(65, 1'b0, 0, 0);

    // N=8: sum (k+1)(k-3) = 60; then an abort in the 4th FETCH cycle.
    for (int k = 0; k < 8; k++) begin x[k] = k + 1; w[k] = k - 3; end
    run(8, 1'b1, 0, 0);
    chk("pin_dot8", result, 60);
    run(8, 1'b0, 5, 0);
    chk("pin_abort_keep", result, 60);

    // Negative real dot product: -2*36 = -72.
    for (int k = 0; k < 8; k++) w[k] = -2;
    run(8, 1'b1, 0, 0);
    chk("pin_relu8", result, 0);
    run(8, 1'b0, 0, 0);
    chk("pin_neg8", result, 18'h3FFB8);

    // Restart during FETCH ignored; abort in DONE and in CLEAR.
    run(4, 1'b0, 0, 3);
    run(2, 1'b0, 6, 0);
    run(3, 1'b0, 1, 0);

    // start with abort in IDLE: abort wins, nothing happens.
    @(posedge clk); #2;
    start = 1'b1; abort = 1'b1; num_inputs = 7'd3;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);

    // Boundary N=64: sum of k = 2016.
    for (int k = 0; k < 64; k++) begin x[k] = 1; w[k] = k; end
    run(64, 1'b0, 0, 0);
    chk("pin_dot64", result, 2016);

    // Asynchronous reset in the first DRAIN cycle.
    @(posedge clk); #2;
    t0 = cyc;
    start = 1'b1; num_inputs = 7'd3; relu_en = 1'b0;
    plan(t0, 3, 1'b0, 0);
    for (int c = t0 + 5; c < MAXC; c++) begin
      e_busy[c] = 1'b0; e_clr[c] = 1'b0; e_push[c] = 1'b0;
      e_mac[c] = 1'b0; e_done[c] = 1'b0;
    end
    fill_res(t0 + 5, '0);
    for (int k = 1; k <= 5; k++) begin @(posedge clk); #2; start = 1'b0; end
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mac_en", mac_en, 0);
    chk("arst_result", result, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
